// File: rtl/uart_cmd_ctrl.sv
// rtl/uart_cmd_ctrl.sv - UART byte sequencer assembling [cmd][data_hi][data_lo] frames
// Acknowledges every received byte, drops stale partial frames on timeout, flags overrun.
module uart_cmd_ctrl #(
  parameter int TIMEOUT_CYCLES = 52080,
  parameter int CNT_W          = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_rdy,
  input  logic [7:0]  rx_data,
  output logic        rx_rdy_clr,
  input  logic        clr_cmd_rdy,
  output logic [7:0]  cmd,
  output logic [15:0] data,
  output logic        cmd_rdy,
  output logic        cmd_ovr,
  output logic        frm_err,
  output logic        busy
);

  localparam logic [1:0] WAIT_CMD = 2'd0;
  localparam logic [1:0] WAIT_HI  = 2'd1;
  localparam logic [1:0] WAIT_LO  = 2'd2;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [7:0]       cmd_buf;
  logic [7:0]       hi_buf;
  logic             take;
  logic             publish;
  logic             timeout;

  // The receiver drops rx_rdy one edge after seeing rx_rdy_clr, so ignore it meanwhile.
  assign take    = rx_rdy & ~rx_rdy_clr;
  assign publish = take & (state == WAIT_LO);
  assign timeout = (state != WAIT_CMD) & ~take & (cnt == CNT_LAST);
  assign busy    = (state != WAIT_CMD);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= WAIT_CMD;
      cnt        <= '0;
      cmd_buf    <= '0;
      hi_buf     <= '0;
      rx_rdy_clr <= 1'b0;
      frm_err    <= 1'b0;
      cmd        <= '0;
      data       <= '0;
      cmd_rdy    <= 1'b0;
      cmd_ovr    <= 1'b0;
    end else begin
      rx_rdy_clr <= take;
      frm_err    <= timeout;

      if (take || timeout || state == WAIT_CMD)
        cnt <= '0;
      else if (cnt != CNT_MAX)
        cnt <= cnt + CNT_W'(1);

      case (state)
        WAIT_CMD: begin
          if (take) begin
            cmd_buf <= rx_data;
            state   <= WAIT_HI;
          end
        end
        WAIT_HI: begin
          if (take) begin
            hi_buf <= rx_data;
            state  <= WAIT_LO;
          end else if (timeout) begin
            state <= WAIT_CMD;
          end
        end
        WAIT_LO: begin
          if (take || timeout)
            state <= WAIT_CMD;
        end
        default: state <= WAIT_CMD;
      endcase

      if (publish) begin
        cmd  <= cmd_buf;
        data <= {hi_buf, rx_data};
      end

      // A publish coinciding with the dispatcher ack counts as fresh, not overrun.
      if (publish)
        cmd_rdy <= 1'b1;
      else if (clr_cmd_rdy)
        cmd_rdy <= 1'b0;

      if (publish && cmd_rdy && !clr_cmd_rdy)
        cmd_ovr <= 1'b1;
      else if (clr_cmd_rdy)
        cmd_ovr <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// tb/tb_uart_cmd_ctrl.sv - scoreboard bench for uart_cmd_ctrl
// Stimulus pushes expected frames; a negedge monitor pops them on each publish.
module tb_uart_cmd_ctrl;

  localparam int T = 200;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx_rdy;
  logic [7:0]  rx_data;
  logic        rx_rdy_clr;
  logic        clr_cmd_rdy;
  logic [7:0]  cmd;
  logic [15:0] data;
  logic        cmd_rdy;
  logic        cmd_ovr;
  logic        frm_err;
  logic        busy;

  uart_cmd_ctrl #(.TIMEOUT_CYCLES(T), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .rx_rdy(rx_rdy), .rx_data(rx_data),
    .rx_rdy_clr(rx_rdy_clr), .clr_cmd_rdy(clr_cmd_rdy), .cmd(cmd), .data(data),
    .cmd_rdy(cmd_rdy), .cmd_ovr(cmd_ovr), .frm_err(frm_err), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]  c;
    logic [15:0] d;
    logic        ovr;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   vectors     = 0;
  int   miscompares = 0;
  int   clr_pulses  = 0;
  int   frm_pulses  = 0;
  logic prev_clr    = 1'b0;
  logic prev_frm    = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Publish is visible as an ack pulse while the FSM is already back in WAIT_CMD.
  always @(negedge clk) begin
    if (rst) begin
      prev_clr = 1'b0;
      prev_frm = 1'b0;
    end else begin
      if (rx_rdy_clr) begin
        clr_pulses++;
        chk("rx_rdy_clr_width", prev_clr, 0);
        if (!busy) begin
          chk("expected_frame_pending", exp_q.size() > 0, 1);
          if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            chk("cmd", cmd, mon_e.c);
            chk("data", data, mon_e.d);
            chk("cmd_rdy", cmd_rdy, 1);
            chk("cmd_ovr", cmd_ovr, mon_e.ovr);
          end
        end
      end
      if (frm_err) begin
        frm_pulses++;
        chk("frm_err_width", prev_frm, 0);
      end
      prev_clr = rx_rdy_clr;
      prev_frm = frm_err;
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit clr_too = 1'b0);
    @(negedge clk);
    rx_data = b;
    rx_rdy  = 1'b1;
    if (clr_too) clr_cmd_rdy = 1'b1;
    @(posedge clk);
    #1;
    clr_cmd_rdy = 1'b0;
    chk("accept_latency", rx_rdy_clr, 1);
    @(posedge clk);
    #1;
    rx_rdy = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] c, input logic [15:0] d, input logic ovr,
                            input int gap, input bit clr_last);
    exp_q.push_back('{c: c, d: d, ovr: ovr});
    send_byte(c);
    repeat (gap) @(posedge clk);
    send_byte(d[15:8]);
    repeat (gap) @(posedge clk);
    send_byte(d[7:0], clr_last);
  endtask

  task automatic ack_cmd(input logic [7:0] c, input logic [15:0] d);
    @(negedge clk);
    clr_cmd_rdy = 1'b1;
    @(posedge clk);
    #1;
    clr_cmd_rdy = 1'b0;
    chk("ack_cmd_rdy", cmd_rdy, 0);
    chk("ack_cmd_ovr", cmd_ovr, 0);
    chk("ack_hold_cmd", cmd, c);
    chk("ack_hold_data", data, d);
  endtask

  initial begin
    int base;
    int fbase;
    int cycles;

    rst = 1'b1; rx_rdy = 1'b0; rx_data = 8'h00; clr_cmd_rdy = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cmd", cmd, 0);
    chk("rst_data", data, 0);
    chk("rst_cmd_rdy", cmd_rdy, 0);
    chk("rst_cmd_ovr", cmd_ovr, 0);
    chk("rst_rx_rdy_clr", rx_rdy_clr, 0);
    chk("rst_frm_err", frm_err, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;

    // Test 1: widely spaced bytes still inside the timeout window
    base = clr_pulses; fbase = frm_pulses;
    send_frame(8'hA5, 16'h1234, 1'b0, T / 2, 1'b0);
    chk("t1_ack_pulses", clr_pulses - base, 3);
    chk("t1_no_frm_err", frm_pulses - fbase, 0);
    ack_cmd(8'hA5, 16'h1234);

    // Test 2: one byte consumed exactly once
    base = clr_pulses;
    send_byte(8'h77);
    repeat (5) @(posedge clk);
    #1;
    chk("t2_single_ack", clr_pulses - base, 1);
    chk("t2_busy", busy, 1);
    exp_q.push_back('{c: 8'h77, d: 16'h8899, ovr: 1'b0});
    send_byte(8'h88);
    send_byte(8'h99);
    ack_cmd(8'h77, 16'h8899);

    // Test 3: partial frame timeout
    fbase = frm_pulses;
    send_byte(8'h01);
    send_byte(8'h02);
    cycles = 1;
    while (!frm_err && cycles < T + 20) begin
      @(posedge clk);
      #1;
      cycles++;
    end
    chk("t3_frm_err_delay", cycles, T);
    @(posedge clk);
    #1;
    chk("t3_frm_err_cleared", frm_err, 0);
    chk("t3_busy", busy, 0);
    chk("t3_frm_pulses", frm_pulses - fbase, 1);
    chk("t3_no_publish", cmd_rdy, 0);
    send_frame(8'h03, 16'h0405, 1'b0, 2, 1'b0);

    // Take in the same cycle the timeout would fire: take wins (cmd_rdy still set -> overrun)
    fbase = frm_pulses;
    exp_q.push_back('{c: 8'h66, d: 16'h7788, ovr: 1'b1});
    send_byte(8'h66);
    repeat (T - 2) @(posedge clk);
    #1;
    send_byte(8'h77);
    chk("t3_edge_busy", busy, 1);
    chk("t3_edge_no_frm_err", frm_pulses - fbase, 0);
    send_byte(8'h88);
    ack_cmd(8'h66, 16'h7788);

    // Test 4: two frames without ack
    send_frame(8'h11, 16'h2233, 1'b0, 0, 1'b0);
    send_frame(8'h44, 16'h5566, 1'b1, 0, 1'b0);
    ack_cmd(8'h44, 16'h5566);

    // Test 5: ack coincides with publish
    send_frame(8'h5A, 16'hBEEF, 1'b0, 0, 1'b0);
    send_frame(8'hC3, 16'h0102, 1'b0, 0, 1'b1);
    ack_cmd(8'hC3, 16'h0102);

    // Test 6: reset mid-frame
    send_frame(8'hE1, 16'hF00D, 1'b0, 0, 1'b0);
    fbase = frm_pulses;
    send_byte(8'h21);
    send_byte(8'h22);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("t6_cmd", cmd, 0);
    chk("t6_data", data, 0);
    chk("t6_cmd_rdy", cmd_rdy, 0);
    chk("t6_busy", busy, 0);
    repeat (T + 10) @(posedge clk);
    #1;
    chk("t6_no_frm_err", frm_pulses - fbase, 0);
    send_frame(8'h31, 16'h3233, 1'b0, 0, 1'b0);

    repeat (4) @(posedge clk);
    #1;
    chk("frames_left_unchecked", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
